pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and a configurable reset value. It replaces bare hold-enable flip-flops between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Stalls propagate by back-pressure (`out_ready` low) instead of a global hold, and branch/exception flushes drop in-flight data without a separate bubble mux. Full throughput is sustained with `in_ready` driven from a register, so no combinational ready path crosses the stage.

---
 rtl/pipe_skid_stage_pkg.sv | 14 +
 rtl/pipe_skid_stage_entry.sv | 22 ++
 rtl/pipe_skid_stage.sv | 107 ++++++++++
 tb/tb_pipe_skid_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants and state encoding for the skid-buffered pipeline stage.
package pipe_skid_stage_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam logic [31:0] DEFAULT_RESET_VALUE = 32'hFFFF_FFFC;

    // Occupancy of the stage: nothing, main only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_stage_entry.sv
// Single payload register with load enable and synchronous reset-to-parameter.
module pipe_entry #(
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // Reset wins over load; otherwise hold unless loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, one-entry skid and flush.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    skid_state_e           state;
    skid_state_e           next_state;
    logic                  accept;
    logic                  drain;
    logic                  main_load;
    logic                  skid_load;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Main entry feeds downstream directly; skid entry catches one stalled beat.
    pipe_entry #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (out_data)
    );

    pipe_entry #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE ('0)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );

    // State register; handshake outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != ST_TWO);
            out_valid <= (next_state != ST_EMPTY);
        end
    end

    // Next-state and entry load control; flush drops both entries and any offered beat.
    always_comb begin
        next_state = state;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = in_data;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        next_state = ST_ONE;
                        main_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        next_state = ST_TWO;
                        skid_load  = 1'b1;
                    end else if (drain) begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        next_state = ST_ONE;
                        main_load  = 1'b1;
                        main_d     = skid_q;
                    end
                end
                default: begin
                    next_state = ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage against a two-deep FIFO model.
module tb_pipe_skid_stage;

    localparam logic [31:0] RV = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of held beats, last shown payload, registered ready.
    logic [31:0] mq[$];
    logic [31:0] m_shown;
    bit          m_in_ready;
    int          n_acc;

    pipe_skid_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] model_exp();
        return {mq.size() != 0, m_in_ready, m_shown};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle after it.
    task automatic cycle(input bit v, input logic [31:0] d, input bit ordy,
                         input bit fl, input bit r);
        bit acc;
        bit drn;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        acc = v && m_in_ready;
        drn = (mq.size() != 0) && ordy;
        if (r) begin
            mq.delete();
            m_shown    = RV;
            m_in_ready = 1'b1;
        end else if (fl) begin
            mq.delete();
            m_in_ready = 1'b1;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(d);
                n_acc++;
            end
            m_in_ready = (mq.size() < 2);
        end
        if (mq.size() != 0) m_shown = mq[0];
        #1;
    endtask

    task automatic test_reset();
        m_shown = 32'h0; m_in_ready = 1'b0;
        cycle(1, 32'h1234, 1, 0, 1);
        cycle(1, 32'h1234, 1, 0, 1);
        n_checks++;
        if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, RV}) begin
            n_errors++;
            $display("FAIL reset: got v=%b r=%b d=%h want v=0 r=1 d=%h", out_valid, in_ready, out_data, RV);
        end
        cycle(1, 32'h4, 1, 0, 0);
        n_checks++;
        if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, 32'h4}) begin
            n_errors++;
            $display("FAIL reset_first_beat: got v=%b r=%b d=%h want v=1 r=1 d=00000004", out_valid, in_ready, out_data);
        end
        cycle(0, 32'h0, 1, 0, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            cycle(1, 32'h10 + 32'(i), 1, 0, 0);
            n_checks++;
            if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, 32'h10 + 32'(i)}) begin
                n_errors++;
                $display("FAIL stream[%0d]: got v=%b r=%b d=%h want v=1 r=1 d=%h",
                         i, out_valid, in_ready, out_data, 32'h10 + 32'(i));
            end
        end
        cycle(0, 32'h0, 1, 0, 0);
    endtask

    task automatic test_skid();
        bit          ordy_pat[6] = '{1, 0, 1, 1, 1, 1};
        logic [31:0] shown[$];
        logic [31:0] want[4] = '{32'hA0, 32'hA0, 32'hA1, 32'hA2};
        int          idx = 0;
        int          low_ready = 0;
        for (int c = 0; c < 6; c++) begin
            bit will_acc;
            will_acc = (idx < 3) && m_in_ready;
            cycle(idx < 3, 32'hA0 + 32'(idx), ordy_pat[c], 0, 0);
            if (will_acc) idx++;
            if (out_valid) shown.push_back(out_data);
            if (!in_ready) low_ready++;
            n_checks++;
            if ({out_valid, in_ready, out_data} !== model_exp()) begin
                n_errors++;
                $display("FAIL skid_cycle[%0d]: got %h want %h", c,
                         {out_valid, in_ready, out_data}, model_exp());
            end
        end
        n_checks++;
        if (low_ready != 1) begin
            n_errors++;
            $display("FAIL skid_ready_low: got %0d cycles want 1", low_ready);
        end
        n_checks++;
        if (shown.size() != 4 || shown[0] !== want[0] || shown[1] !== want[1] ||
            shown[2] !== want[2] || shown[3] !== want[3]) begin
            n_errors++;
            $display("FAIL skid_sequence: got %p want %p", shown, want);
        end
    endtask

    task automatic test_long_stall();
        int          acc0;
        logic [31:0] got[$];
        int          idx = 0;
        acc0 = n_acc;
        for (int c = 0; c < 5; c++) begin
            bit will_acc;
            will_acc = m_in_ready;
            cycle(1, 32'hC0 + 32'(idx), 0, 0, 0);
            if (will_acc) idx++;
        end
        n_checks++;
        if (n_acc - acc0 != 2 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL long_stall_accepts: got %0d accepts ready=%b want 2 ready=0", n_acc - acc0, in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            if (out_valid) got.push_back(out_data);
            cycle(0, 32'h0, 1, 0, 0);
        end
        n_checks++;
        if (got.size() != 2 || got[0] !== 32'hC0 || got[1] !== 32'hC1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL long_stall_drain: got %p valid=%b want C0,C1 then empty", got, out_valid);
        end
    endtask

    task automatic test_flush();
        cycle(1, 32'hB0, 1, 0, 0);
        cycle(1, 32'hB1, 0, 0, 0);
        cycle(1, 32'hB2, 0, 1, 0);
        n_checks++;
        if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 32'hB0}) begin
            n_errors++;
            $display("FAIL flush: got v=%b r=%b d=%h want v=0 r=1 d=000000b0", out_valid, in_ready, out_data);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(0, 32'h0, 1, 0, 0);
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== 32'hB0) begin
                n_errors++;
                $display("FAIL flush_after[%0d]: got v=%b d=%h want v=0 d=000000b0", c, out_valid, out_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 32'hD0, 1, 0, 0);
        cycle(1, 32'hD1, 0, 0, 0);
        cycle(1, 32'hD2, 1, 1, 1);
        n_checks++;
        if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, RV}) begin
            n_errors++;
            $display("FAIL reset_mid: got v=%b r=%b d=%h want v=0 r=1 d=%h", out_valid, in_ready, out_data, RV);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(0, 32'h0, 1, 0, 0);
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== RV) begin
                n_errors++;
                $display("FAIL reset_mid_after[%0d]: got v=%b d=%h want v=0 d=%h", c, out_valid, out_data, RV);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit v, ordy, fl, r;
            v    = ($urandom_range(3, 0) != 0);
            ordy = ($urandom_range(2, 0) != 0);
            fl   = ($urandom_range(15, 0) == 0);
            r    = ($urandom_range(63, 0) == 0);
            cycle(v, $urandom, ordy, fl, r);
            n_checks++;
            if ({out_valid, in_ready, out_data} !== model_exp()) begin
                n_errors++;
                $display("FAIL random[%0d]: got %h want %h", c,
                         {out_valid, in_ready, out_data}, model_exp());
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        n_acc = 0;
        test_reset();
        test_streaming();
        test_skid();
        test_long_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
